// File: rtl/uart_rx.sv
// UART receiver: samples an already-synchronized RX line mid-bit and presents each good
// frame through a single-entry valid/ready output register, pulsing on framing errors and overruns.
module uart_rx #(
  parameter int clks_per_bit = 217,
  parameter int data_width   = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  rx_i,
  output logic [data_width-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int CNT_W = $clog2(clks_per_bit);
  localparam int IDX_W = $clog2(data_width + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(clks_per_bit / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(clks_per_bit - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(data_width - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } state_e;

  state_e                  state_q,     state_d;
  logic [CNT_W-1:0]        clk_cnt_q,   clk_cnt_d;
  logic [IDX_W-1:0]        bit_idx_q,   bit_idx_d;
  logic [data_width-1:0]   shift_q,     shift_d;
  logic [data_width-1:0]   data_q,      data_d;
  logic                    valid_q,     valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overrun_q,   overrun_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_i) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end

      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          if (!rx_i) begin
            state_d   = DATA;
            clk_cnt_d = '0;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          // LSB arrives first, so shifting right from the MSB leaves the byte in order.
          shift_d   = {rx_i, shift_q[data_width-1:1]};
          clk_cnt_d = '0;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_i) begin
            state_d = IDLE;
            // A draining buffer counts as free, so back-to-back bytes never stall.
            if (!valid_q || ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = RECOVER;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      RECOVER: begin
        if (rx_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

  a_pulses_exclusive: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(frame_err_o && overrun_o));

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized traffic, checked every cycle against
// a frame-level model of the output buffer and error pulses.
module tb_uart_rx;

  localparam int N = 16;
  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         rx_i;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         frame_err_o;
  logic         overrun_o;

  always #5 clk_i = ~clk_i;

  uart_rx #(
    .clks_per_bit(N),
    .data_width  (W)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  typedef struct {
    int           at;
    logic [W-1:0] data;
    logic         ok;
  } frame_t;

  frame_t       frameQ[$];
  frame_t       mFrame;
  int           cyc = 0;
  int           checkCount = 0;
  int           errorCount = 0;
  int           lastStopEdge = 0;
  int           r;
  logic         mValid = 1'b0;
  logic [W-1:0] mData = '0;
  logic         expFe = 1'b0;
  logic         expOv = 1'b0;
  logic         checkEn = 1'b0;
  logic         randPhase = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Frame-level model: each frame resolves at its stop-bit sample edge into a load,
  // an overrun or a framing error; the buffer empties on any handshake.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    expFe = 1'b0;
    expOv = 1'b0;
    if (rstn_i) begin
      if (mValid && ready_i) mValid = 1'b0;
      if (frameQ.size() > 0 && frameQ[0].at == cyc) begin
        mFrame = frameQ.pop_front();
        if (!mFrame.ok) begin
          expFe = 1'b1;
        end else if (!mValid) begin
          mValid = 1'b1;
          mData  = mFrame.data;
        end else begin
          expOv = 1'b1;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (checkEn && rstn_i) begin
      checkOutput("valid_o", 32'(valid_o), 32'(mValid));
      if (mValid) checkOutput("data_o", 32'(data_o), 32'(mData));
      checkOutput("frame_err_o", 32'(frame_err_o), 32'(expFe));
      checkOutput("overrun_o", 32'(overrun_o), 32'(expOv));
    end
  end

  // Drives one frame; the stop bit is sampled N/2 + (W+1)*N edges after the first low edge.
  task automatic applyStimulus(input logic [W-1:0] b, input logic stopOk, input int extraLow);
    frame_t f;
    @(negedge clk_i);
    rx_i   = 1'b0;
    f.at   = cyc + 1 + N / 2 + (W + 1) * N;
    f.data = b;
    f.ok   = stopOk;
    frameQ.push_back(f);
    lastStopEdge = f.at;
    repeat (N) @(negedge clk_i);
    for (int k = 0; k < W; k++) begin
      rx_i = b[k];
      repeat (N) @(negedge clk_i);
    end
    rx_i = stopOk;
    repeat (N) @(negedge clk_i);
    if (!stopOk) begin
      repeat (extraLow) @(negedge clk_i);
      rx_i = 1'b1;
      repeat (2) @(negedge clk_i);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic pulseReady();
    @(negedge clk_i);
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic glitch(input int len);
    @(negedge clk_i);
    rx_i = 1'b0;
    repeat (len) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (N) @(negedge clk_i);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn_i  = 1'b0;
    rx_i    = 1'b1;
    ready_i = 1'b0;
    #1;
    checkOutput("reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset data_o", 32'(data_o), 32'd0);
    checkOutput("reset frame_err_o", 32'(frame_err_o), 32'd0);
    checkOutput("reset overrun_o", 32'(overrun_o), 32'd0);
    idle(3);
    rstn_i  = 1'b1;
    checkEn = 1'b1;
    idle(4);

    $display("[TB] held byte released by a single ready pulse");
    applyStimulus(8'hA5, 1'b1, 0);
    idle(20);
    pulseReady();
    idle(5);

    $display("[TB] short low glitch then a real frame");
    glitch(4);
    applyStimulus(8'h3C, 1'b1, 0);
    idle(3);
    pulseReady();

    $display("[TB] low stop bit followed by a long break");
    applyStimulus(8'h55, 1'b0, 100);
    idle(5);
    applyStimulus(8'h0F, 1'b1, 0);
    idle(3);
    pulseReady();

    $display("[TB] back-to-back frames into a full buffer");
    applyStimulus(8'h11, 1'b1, 0);
    applyStimulus(8'h22, 1'b1, 0);
    idle(10);
    pulseReady();
    idle(3);

    $display("[TB] drain and reload on the same cycle");
    applyStimulus(8'h11, 1'b1, 0);
    idle(5);
    fork
      applyStimulus(8'h22, 1'b1, 0);
      begin
        @(negedge clk_i);
        #1;
        while (cyc < lastStopEdge - 1) @(negedge clk_i);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
      end
    join
    idle(3);

    $display("[TB] reset in the middle of a frame");
    fork
      applyStimulus(8'hFF, 1'b1, 0);
      begin
        @(negedge clk_i);
        #1;
        while (cyc < lastStopEdge - (W + 1) * N + 5 * N - 1) @(negedge clk_i);
        rstn_i = 1'b0;
        frameQ.delete();
        mValid = 1'b0;
        #1;
        checkOutput("async reset valid_o", 32'(valid_o), 32'd0);
        checkOutput("async reset data_o", 32'(data_o), 32'd0);
        checkOutput("async reset frame_err_o", 32'(frame_err_o), 32'd0);
        checkOutput("async reset overrun_o", 32'(overrun_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
      end
    join
    idle(4);
    applyStimulus(8'h81, 1'b1, 0);
    idle(3);
    pulseReady();

    $display("[TB] randomized frames, glitches, breaks and ready");
    randPhase = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          r = $urandom_range(0, 9);
          if (r == 0) begin
            glitch($urandom_range(1, N / 2 - 2));
          end else begin
            applyStimulus(8'($urandom), r != 1, $urandom_range(0, 40));
          end
          idle($urandom_range(0, 12));
        end
        randPhase = 1'b0;
      end
      begin
        while (randPhase) begin
          @(negedge clk_i);
          ready_i = ($urandom_range(0, 2) == 0);
        end
      end
    join
    ready_i = 1'b1;
    idle(3);
    ready_i = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
